// File: rtl/seq_multiplier_4bit.sv
// Unsigned N x N shift-and-add sequential multiplier with a 2N-bit product.
// One start pulse captures both operands; the result appears N+1 edges later.
module seq_multiplier_4bit #(
  parameter int unsigned N = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N-1:0]     multplcnd_i,
  input  logic [N-1:0]     multplr_i,
  input  logic             mul_enable_i,
  output logic [2*N-1:0]   product_o
);

  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N:0]       acc_q, acc_d;
  logic [N:0]       sum;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     mplr_q, mplr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2*N-1:0]   product_d;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      count_q   <= '0;
      product_o <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      count_q   <= count_d;
      product_o <= product_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    count_d   = count_q;
    product_d = product_o;
    sum       = acc_q;

    case (state_q)
      IDLE: begin
        if (mul_enable_i) begin
          mcand_d = multplcnd_i;
          mplr_d  = multplr_i;
          acc_d   = '0;
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Carry bit of sum is kept so that the maximum product does not overflow
        if (mplr_q[0]) begin
          sum = {1'b0, acc_q[N-1:0]} + {1'b0, mcand_q};
        end
        mplr_d  = {sum[0], mplr_q[N-1:1]};
        acc_d   = {1'b0, sum[N:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        product_d = {acc_q[N-1:0], mplr_q};
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_multiplier_4bit.sv
// Self-checking bench for seq_multiplier_4bit: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_seq_multiplier_4bit;

  localparam int unsigned LAT = 5;

  logic       clk_i;
  logic       reset_i;
  logic [3:0] multplcnd_i;
  logic [3:0] multplr_i;
  logic       mul_enable_i;
  logic [7:0] product_o;

  int checks = 0;
  int errors = 0;

  seq_multiplier_4bit #(.N(4)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .multplcnd_i  (multplcnd_i),
    .multplr_i    (multplr_i),
    .mul_enable_i (mul_enable_i),
    .product_o    (product_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: an accepted start yields a*b exactly LAT edges later;
  // no new start is accepted until the edge after the result lands.
  logic [7:0] exp_product = 8'h00;
  logic [7:0] pend_result = 8'h00;
  bit         pending     = 1'b0;
  int         edge_cnt    = 0;
  int         done_at     = 0;

  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      exp_product = 8'h00;
      pending     = 1'b0;
      edge_cnt    = 0;
    end else begin
      edge_cnt = edge_cnt + 1;
      if (pending) begin
        if (edge_cnt == done_at) begin
          exp_product = pend_result;
          pending     = 1'b0;
        end
      end else if (mul_enable_i) begin
        pend_result = 8'(int'(multplcnd_i) * int'(multplr_i));
        pending     = 1'b1;
        done_at     = edge_cnt + LAT;
      end
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%02h exp=0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare on the falling edge, then drive the next input set
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic en);
    @(negedge clk_i);
    check("model", product_o, exp_product);
    multplcnd_i  = a;
    multplr_i    = b;
    mul_enable_i = en;
  endtask

  initial begin
    reset_i      = 1'b0;
    multplcnd_i  = 4'd0;
    multplr_i    = 4'd0;
    mul_enable_i = 1'b0;

    // Reset then idle
    repeat (4) step(4'd0, 4'd0, 1'b0);
    check("reset_val", product_o, 8'h00);
    reset_i = 1'b1;
    repeat (4) step(4'd0, 4'd0, 1'b0);
    check("idle_zero", product_o, 8'h00);

    // Basic 7 x 8, operands wiggled while busy and after
    step(4'd7, 4'd8, 1'b1);
    repeat (5) step(4'($urandom), 4'($urandom), 1'b0);
    check("basic_before", product_o, 8'h00);
    step(4'($urandom), 4'($urandom), 1'b0);
    check("basic_56", product_o, 8'h38);
    repeat (3) step(4'($urandom), 4'($urandom), 1'b0);
    check("basic_hold", product_o, 8'h38);

    // Maximum operands
    step(4'd15, 4'd15, 1'b1);
    repeat (5) step(4'd15, 4'd15, 1'b0);
    check("max_before", product_o, 8'h38);
    step(4'd0, 4'd0, 1'b0);
    check("max_225", product_o, 8'hE1);

    // Enable during BUSY is ignored
    step(4'd3, 4'd5, 1'b1);
    step(4'd9, 4'd9, 1'b0);
    step(4'd9, 4'd9, 1'b1);
    step(4'd9, 4'd9, 1'b0);
    repeat (3) step(4'd9, 4'd9, 1'b0);
    check("busy_ign_15", product_o, 8'h0F);
    repeat (8) step(4'd9, 4'd9, 1'b0);
    check("busy_ign_hold", product_o, 8'h0F);

    // Reset mid-operation
    step(4'd12, 4'd11, 1'b1);
    step(4'd12, 4'd11, 1'b0);
    step(4'd12, 4'd11, 1'b0);
    reset_i = 1'b0;
    #1;
    check("reset_async", product_o, 8'h00);
    step(4'd0, 4'd0, 1'b0);
    reset_i = 1'b1;
    repeat (8) step(4'd0, 4'd0, 1'b0);
    check("reset_after", product_o, 8'h00);

    // Back-to-back with enable held: 0 x 13 then 10 x 6
    step(4'd0, 4'd13, 1'b1);
    repeat (11) step(4'd10, 4'd6, 1'b1);
    check("b2b_before", product_o, 8'h00);
    step(4'd10, 4'd6, 1'b1);
    check("b2b_60", product_o, 8'h3C);
    repeat (5) step(4'd10, 4'd6, 1'b0);
    check("b2b_hold", product_o, 8'h3C);
    repeat (8) step(4'd0, 4'd0, 1'b0);

    // Random stimulus with occasional asynchronous reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        @(negedge clk_i);
        check("model", product_o, exp_product);
        reset_i = 1'b0;
        #1;
        check("rand_reset", product_o, 8'h00);
        step(4'($urandom), 4'($urandom), 1'b0);
        reset_i = 1'b1;
      end else begin
        step(4'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
      end
    end
    repeat (8) step(4'd0, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
